fetch_sequencer: RTL and testbench

//  Owns the IF-stage program counter of the pipelined core and sequences instruction-memory fetches.

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_skid_slot.sv | 30 +++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP encoding and FSM states for the IF-stage fetch sequencer.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_skid_slot.sv
// fetch_skid_slot: one-entry data+valid holding register with load, unload and flush.
module fetch_skid_slot #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic         i_unload,
   input  logic         i_flush,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_valid
);
   logic [W-1:0] r_data;
   logic         r_valid;

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_unload) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage PC owner; issues imem fetches, buffers one instruction for decode,
// honours stall_f and executes EX redirects.
module fetch_sequencer import fetch_pkg::*; #(
   parameter int               XLEN         = fetch_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter logic [31:0]      NOP_INSTR    = fetch_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_f,
   input  logic            redirect_e,
   input  logic [XLEN-1:0] redirect_pc_e,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] pcf,
   output logic [31:0]     instr_f,
   output logic            instr_valid_f
);
   fetch_state_t    r_state, w_state_n;
   logic [XLEN-1:0] r_pc, w_pc_n, r_addr, r_pcf, w_pcf_n, w_tgt;
   logic [31:0]     r_instr, w_instr_n, w_skid_data;
   logic            r_valid, w_valid_n, w_consume, w_space;
   logic            w_load, w_unload, w_flush, w_skid_valid;

   assign w_consume = r_valid && !stall_f;
   assign w_space   = !r_valid || w_consume;
   assign w_tgt     = {redirect_pc_e[XLEN-1:2], 2'b00};

   fetch_skid_slot #(.W(32)) u_skid (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .i_unload (w_unload),
      .i_flush  (w_flush),
      .i_data   (imem_rdata),
      .o_data   (w_skid_data),
      .o_valid  (w_skid_valid)
   );

   always_comb begin
      w_state_n = r_state;
      w_pc_n    = r_pc;
      w_pcf_n   = r_pcf;
      w_valid_n = r_valid && !w_consume;
      w_instr_n = w_consume ? NOP_INSTR : r_instr;
      w_load    = 1'b0;
      w_unload  = 1'b0;
      w_flush   = 1'b0;
      if (redirect_e) begin
         w_pc_n    = w_tgt;
         w_valid_n = 1'b0;
         w_instr_n = NOP_INSTR;
         w_flush   = 1'b1;
         // an unacked request is still in flight and must be drained before refetching
         w_state_n = ((r_state == REQ || r_state == DRAIN) && !imem_ack) ? DRAIN : REQ;
      end else begin
         case (r_state)
            BOOT: w_state_n = REQ;
            REQ: begin
               if (imem_ack) begin
                  w_pc_n = r_pc + XLEN'(4);
                  if (w_space) begin
                     w_pcf_n   = r_pc;
                     w_instr_n = imem_rdata;
                     w_valid_n = 1'b1;
                  end else begin
                     w_load    = 1'b1;
                     w_state_n = HOLD;
                  end
               end
            end
            HOLD: begin
               if (w_consume && w_skid_valid) begin
                  w_pcf_n   = r_pc - XLEN'(4);
                  w_instr_n = w_skid_data;
                  w_valid_n = 1'b1;
                  w_unload  = 1'b1;
                  w_state_n = REQ;
               end
            end
            default: w_state_n = imem_ack ? REQ : DRAIN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= BOOT;
         r_pc    <= RESET_VECTOR;
         r_addr  <= RESET_VECTOR;
         r_pcf   <= RESET_VECTOR;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_pc    <= w_pc_n;
         r_addr  <= (w_state_n == DRAIN) ? r_addr : w_pc_n;
         r_pcf   <= w_pcf_n;
         r_instr <= w_instr_n;
         r_valid <= w_valid_n;
      end
   end

   assign imem_req      = (r_state == REQ) || (r_state == DRAIN);
   assign imem_addr     = r_addr;
   assign pcf           = r_pcf;
   assign instr_f       = r_instr;
   assign instr_valid_f = r_valid;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: variable-latency memory model plus an in-order fetch-stream scoreboard.
module tb_fetch_sequencer;
   import fetch_pkg::*;
   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 0, reset = 1, stall_f = 0, redirect_e = 0, imem_ack = 0;
   logic [31:0] redirect_pc_e = 0, imem_rdata = 0;
   logic        imem_req, instr_valid_f;
   logic [31:0] imem_addr, pcf, instr_f;

   int          errors = 0, checks = 0;
   int          lat = 0, wcnt = 0, nv;
   logic        stray = 0, seen;
   logic [31:0] exp_pc = RV, a;
   logic        p_req, p_ack, p_redir, p_rst;
   logic [31:0] p_addr;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .stall_f       (stall_f),
      .redirect_e    (redirect_e),
      .redirect_pc_e (redirect_pc_e),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .pcf           (pcf),
      .instr_f       (instr_f),
      .instr_valid_f (instr_valid_f)
   );

   function automatic logic [31:0] mem(input logic [31:0] addr);
      return addr ^ {addr[15:0], 16'hBEEF} ^ 32'h1357_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Entered at a negedge: respond as memory, score the upcoming edge, advance one cycle.
   task automatic cycle();
      if (!imem_req) begin
         wcnt       = 0;
         imem_ack   = stray;
         imem_rdata = 32'hDEAD_BEEF;
      end else begin
         imem_ack   = (wcnt >= lat);
         wcnt       = imem_ack ? 0 : wcnt + 1;
         imem_rdata = imem_ack ? mem(imem_addr) : (32'hBAD0_0000 ^ $urandom);
      end
      if (!instr_valid_f) check("nop", instr_f, NOP_INSTR);
      if (reset) exp_pc = RV;
      else if (redirect_e) exp_pc = redirect_pc_e & 32'hFFFF_FFFC;
      else if (instr_valid_f && !stall_f) begin
         check("pcf", pcf, exp_pc);
         check("instr", instr_f, mem(pcf));
         exp_pc += 4;
      end
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_redir = redirect_e && !reset; p_rst = reset;
      @(posedge clk);
      @(negedge clk);
      if (p_redir) check("flush", instr_valid_f, 0);
      if (p_req && !p_ack && !p_rst) begin
         check("req_hold", imem_req, 1);
         check("addr_hold", imem_addr, p_addr);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      cycle();
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, RV);
      check("rst_pcf", pcf, RV);
      check("rst_valid", instr_valid_f, 0);
      check("rst_instr", instr_f, NOP_INSTR);
      reset = 0;
      cycle();
      check("t1_req", imem_req, 1);
      check("t1_a0", imem_addr, 32'h0);
      check("t1_v0", instr_valid_f, 0);
      cycle();
      check("t1_a4", imem_addr, 32'h4);
      check("t1_pcf", pcf, 32'h0);
      check("t1_v1", instr_valid_f, 1);
      cycle();
      check("t1_a8", imem_addr, 32'h8);
      cycle();
      check("t2_pcf8", pcf, 32'h8);
      stall_f = 1;
      repeat (4) begin
         cycle();
         check("t2_hold_pcf", pcf, 32'h8);
         check("t2_hold_req", imem_req, 0);
      end
      stall_f = 0;
      cycle();
      check("t2_next", pcf, 32'hC);
      nv = 0;
      repeat (10) begin cycle(); nv += int'(instr_valid_f); end
      check("t2_rate", nv, 10);

      lat = 3;
      repeat (8) cycle();
      nv = 0;
      repeat (16) begin cycle(); nv += int'(instr_valid_f); end
      check("t3_rate", nv, 4);

      for (int i = 0; i < 8 && !(imem_req && wcnt == 1); i++) cycle();
      a = imem_addr;
      redirect_e = 1; redirect_pc_e = 32'h100;
      cycle();
      redirect_e = 0;
      check("t4_drain_req", imem_req, 1);
      check("t4_drain_addr", imem_addr, a);
      for (int i = 0; i < 10 && imem_addr == a; i++) cycle();
      check("t4_tgt", imem_addr, 32'h100);
      for (int i = 0; i < 10 && !instr_valid_f; i++) cycle();
      check("t4_pcf", pcf, 32'h100);

      lat = 0;
      repeat (3) cycle();
      stall_f = 1; redirect_e = 1; redirect_pc_e = 32'h103;
      cycle();
      stall_f = 0; redirect_e = 0;
      check("t5_v", instr_valid_f, 0);
      for (int i = 0; i < 5 && !instr_valid_f; i++) cycle();
      check("t5_pcf", pcf, 32'h100);

      redirect_e = 1; redirect_pc_e = 32'hFFFF_FFF4;
      cycle();
      redirect_e = 0;
      seen = 0;
      repeat (10) begin cycle(); seen |= instr_valid_f && pcf == 32'h0; end
      check("wrap", seen, 1);

      lat = 3;
      for (int i = 0; i < 8 && !(imem_req && wcnt == 2); i++) cycle();
      reset = 1;
      cycle();
      check("t6_pcf", pcf, RV);
      check("t6_valid", instr_valid_f, 0);
      check("t6_req", imem_req, 0);
      reset = 0; stray = 1;
      cycle();
      stray = 0;
      check("t6_boot_v", instr_valid_f, 0);
      check("t6_boot_req", imem_req, 1);
      check("t6_boot_addr", imem_addr, RV);

      repeat (800) begin
         if ($urandom_range(0, 49) == 0) lat = $urandom_range(0, 3);
         stall_f = $urandom_range(0, 9) < 3;
         redirect_e = $urandom_range(0, 29) == 0;
         redirect_pc_e = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
         cycle();
      end
      stall_f = 0; redirect_e = 0;
      repeat (10) cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
